// File: rtl/mic_recorder_if.sv
// Signal bundle between the PDM capture block and its surroundings:
// mic pins, record button, BRAM write port and status.
interface mic_recorder_if;
  logic        record_button;
  logic        mic_data;
  logic        mic_clk;
  logic        mic_lrsel;
  // bram_we is a one-cycle strobe with no back-pressure. bram_addr and
  // bram_data are valid whenever bram_we is 1 and stay unchanged around it.
  logic        bram_we;
  logic [15:0] bram_addr;
  logic [31:0] bram_data;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  modport dev (
    input  record_button, mic_data,
    output mic_clk, mic_lrsel, bram_we, bram_addr, bram_data, busy, done, dbg_state
  );

  modport host (
    output record_button, mic_data,
    input  mic_clk, mic_lrsel, bram_we, bram_addr, bram_data, busy, done, dbg_state
  );
endinterface

// File: rtl/mic_recorder.sv
// PDM microphone capture: divides the system clock down to mic_clk, packs 32
// samples per word (first sample in bit 31) and writes NUM_WORDS words to BRAM.
module mic_recorder #(
  parameter int CLK_DIV   = 100,
  parameter int SAMPLE_PT = 99,
  parameter int NUM_WORDS = 869
) (
  input  logic        clkout_sys,
  input  logic        reset,
  mic_recorder_if.dev bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] TICK_AT   = DIV_W'(SAMPLE_PT);
  localparam logic [9:0]       LAST_WORD = 10'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             mic_clk_q;
  logic             btn_q;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       word_addr_q, word_addr_d;
  logic [31:0]      shift_q, shift_d;
  logic [31:0]      data_q, data_d;
  logic [15:0]      addr_q, addr_d;
  logic             sample_tick;
  logic             start;

  assign div_cnt_d   = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
  assign sample_tick = (div_cnt_q == TICK_AT);
  assign start       = bus.record_button & ~btn_q;

  always_ff @(posedge clkout_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      mic_clk_q   <= 1'b0;
      btn_q       <= 1'b0;
      bit_cnt_q   <= '0;
      word_addr_q <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      addr_q      <= 16'h8000;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      mic_clk_q   <= (div_cnt_q < DIV_HALF);
      btn_q       <= bus.record_button;
      bit_cnt_q   <= bit_cnt_d;
      word_addr_q <= word_addr_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    word_addr_d = word_addr_q;
    shift_d     = shift_q;
    data_d      = data_q;
    addr_d      = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          word_addr_d = '0;
          bit_cnt_d   = '0;
          state_d     = S_ARM;
        end
      end
      // ARM treats its first tick exactly like a CAPTURE tick
      S_ARM, S_CAPTURE: begin
        if (sample_tick) begin
          shift_d = {shift_q[30:0], bus.mic_data};
          if (bit_cnt_q == 6'd31) begin
            bit_cnt_d = '0;
            data_d    = shift_d;
            addr_d    = {1'b1, word_addr_q, 5'b00000};
            state_d   = S_WRITE;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            state_d   = S_CAPTURE;
          end
        end
      end
      S_WRITE: begin
        if (word_addr_q == LAST_WORD) begin
          state_d = S_DONE;
        end else begin
          word_addr_d = word_addr_q + 10'd1;
          state_d     = S_CAPTURE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mic_clk   = mic_clk_q;
  assign bus.mic_lrsel = 1'b0;
  assign bus.bram_we   = (state_q == S_WRITE);
  assign bus.bram_addr = addr_q;
  assign bus.bram_data = data_q;
  assign bus.busy      = (state_q == S_ARM) || (state_q == S_CAPTURE) || (state_q == S_WRITE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.dbg_state = state_q;
endmodule
